// File: rtl/truth_table_engine_if.sv
// truth_table_engine_if: table write, evaluation and sweep stream signals of the truth-table engine
interface truth_table_engine_if #(
    parameter int N = 3
);
    logic              tt_wr;
    logic [(1<<N)-1:0] tt_data;
    logic [N-1:0]      inp;
    logic              out;
    logic              start;
    logic              busy;
    logic              s_valid;
    logic              s_ready;
    logic [N-1:0]      s_idx;
    logic              s_bit;
    logic              done;
    logic [N:0]        ones_count;
    modport master (
        output tt_wr, tt_data, inp, start, s_ready,
        input  out, busy, s_valid, s_idx, s_bit, done, ones_count
    );
    modport slave (
        input  tt_wr, tt_data, inp, start, s_ready,
        output out, busy, s_valid, s_idx, s_bit, done, ones_count
    );
endinterface

// File: rtl/truth_table_engine.sv
// truth_table_engine: programmable N-input truth table with registered lookup and a row-streaming sweep
module truth_table_engine #(
    parameter int N = 3
) (
    input logic                 clk,
    input logic                 rst,
    truth_table_engine_if.slave bus
);
    localparam int D = 1 << N;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t       state_q, state_d;
    logic [D-1:0] tbl_q, tbl_d;
    logic [N-1:0] idx_q, idx_d;
    logic [N:0]   ones_q, ones_d;
    logic         out_q, out_d;
    logic         run, last;
    always_comb begin
        run     = state_q == RUN;
        last    = &idx_q;
        tbl_d   = (bus.tt_wr && state_q == IDLE) ? bus.tt_data : tbl_q;
        out_d   = tbl_q[bus.inp];
        state_d = state_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        if (state_q == IDLE && bus.start) begin
            state_d = RUN;
            idx_d   = '0;
            ones_d  = '0;
        end else if (run && bus.s_ready) begin
            ones_d  = ones_q + (N+1)'(tbl_q[idx_q]);
            idx_d   = last ? idx_q : idx_q + N'(1);
            state_d = last ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tbl_q   <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tbl_q   <= tbl_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            out_q   <= out_d;
        end
    end
    assign bus.out        = out_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.s_valid    = run;
    assign bus.s_idx      = idx_q;
    assign bus.s_bit      = run & tbl_q[idx_q];
    assign bus.done       = state_q == DONE;
    assign bus.ones_count = ones_q;
endmodule

// File: tb/tb_truth_table_engine.sv
// tb_truth_table_engine: directed bench for N=3 and N=8 engines with a per-cycle reference model
module tb_truth_table_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    truth_table_engine_if #(.N(3)) if3();
    truth_table_engine_if #(.N(8)) if8();
    truth_table_engine #(.N(3)) u3 (.clk(clk), .rst(rst), .bus(if3));
    truth_table_engine #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

    int checks = 0;
    int failures = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model for the N=3 engine: a table, a pending-row counter and a done flag
    bit [7:0] m_table;
    bit       m_out, m_run, m_done, m_live, m_busy_was;
    int       m_next, m_ones;
    always @(posedge clk) begin
        if (rst) begin
            m_table = '0; m_out = 0; m_run = 0; m_done = 0; m_next = 0; m_ones = 0; m_live = 1;
        end else if (m_live) begin
            m_busy_was = m_run || m_done;
            m_out = m_table[if3.inp];
            if (m_done) m_done = 0;
            else if (m_run) begin
                if (if3.s_ready) begin
                    m_ones += int'(m_table[m_next]);
                    if (m_next == 7) begin m_run = 0; m_done = 1; end
                    else m_next++;
                end
            end else if (if3.start) begin
                m_run = 1; m_next = 0; m_ones = 0;
            end
            if (if3.tt_wr && !m_busy_was) m_table = if3.tt_data;
        end
    end
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_out", 32'(if3.out), 32'(m_out));
            chk("m_busy", 32'(if3.busy), 32'(m_run || m_done));
            chk("m_valid", 32'(if3.s_valid), 32'(m_run));
            chk("m_done", 32'(if3.done), 32'(m_done));
            chk("m_ones", 32'(if3.ones_count), 32'(m_ones));
            if (m_run) begin
                chk("m_idx", 32'(if3.s_idx), 32'(m_next));
                chk("m_bit", 32'(if3.s_bit), 32'(m_table[m_next]));
            end else chk("m_bit_idle", 32'(if3.s_bit), 32'd0);
        end
    end

    bit exp_out[8] = '{0, 0, 0, 1, 0, 1, 1, 0};
    int row;

    task automatic chk_zero3(input string tag);
        chk({tag, "_out"}, 32'(if3.out), 0);
        chk({tag, "_busy"}, 32'(if3.busy), 0);
        chk({tag, "_valid"}, 32'(if3.s_valid), 0);
        chk({tag, "_idx"}, 32'(if3.s_idx), 0);
        chk({tag, "_bit"}, 32'(if3.s_bit), 0);
        chk({tag, "_done"}, 32'(if3.done), 0);
        chk({tag, "_ones"}, 32'(if3.ones_count), 0);
    endtask

    initial begin
        rst = 1;
        if3.tt_wr = 1; if3.tt_data = 8'hFF; if3.inp = 3'd7; if3.start = 1; if3.s_ready = 1;
        if8.tt_wr = 1; if8.tt_data = '1; if8.inp = '1; if8.start = 1; if8.s_ready = 1;
        repeat (2) @(negedge clk);
        chk_zero3("rst3");
        chk("rst8_out", 32'(if8.out), 0);
        chk("rst8_busy", 32'(if8.busy), 0);
        chk("rst8_done", 32'(if8.done), 0);
        chk("rst8_ones", 32'(if8.ones_count), 0);
        rst = 0;
        if3.tt_wr = 0; if3.start = 0;
        if8.tt_wr = 0; if8.start = 0;
        @(negedge clk);
        chk("rst_tbl3", 32'(if3.out), 0);
        chk("rst_tbl8", 32'(if8.out), 0);

        // evaluation of 8'h68, one cycle latency
        if3.tt_data = 8'h68; if3.tt_wr = 1;
        @(negedge clk);
        if3.tt_wr = 0;
        for (int i = 0; i < 8; i++) begin
            if3.inp = 3'(i);
            @(negedge clk);
            chk("eval", 32'(if3.out), 32'(exp_out[i]));
        end

        // full-rate sweep
        if3.start = 1;
        @(negedge clk);
        if3.start = 0;
        for (int i = 0; i < 8; i++) begin
            chk("sw_valid", 32'(if3.s_valid), 1);
            chk("sw_idx", 32'(if3.s_idx), 32'(i));
            chk("sw_bit", 32'(if3.s_bit), 32'(exp_out[i]));
            @(negedge clk);
        end
        chk("sw_done", 32'(if3.done), 1);
        chk("sw_ones", 32'(if3.ones_count), 3);
        @(negedge clk);
        chk("sw_done_once", 32'(if3.done), 0);
        chk("sw_busy_fall", 32'(if3.busy), 0);
        chk("sw_ones_hold", 32'(if3.ones_count), 3);

        // backpressure with s_ready pattern 1,0,0,1
        if3.start = 1;
        @(negedge clk);
        if3.start = 0;
        row = 0;
        for (int c = 0; c < 100 && !if3.done; c++) begin
            if3.s_ready = (c % 4 == 0) || (c % 4 == 3);
            if (if3.s_valid) begin
                chk("bp_idx", 32'(if3.s_idx), 32'(row));
                chk("bp_bit", 32'(if3.s_bit), 32'(exp_out[row % 8]));
                if (if3.s_ready) row++;
            end
            @(negedge clk);
        end
        chk("bp_rows", 32'(row), 8);
        chk("bp_done", 32'(if3.done), 1);
        chk("bp_ones", 32'(if3.ones_count), 3);
        if3.s_ready = 1;
        @(negedge clk);

        // tt_wr and start issued mid-sweep must be ignored
        if3.start = 1;
        @(negedge clk);
        if3.start = 0;
        repeat (3) @(negedge clk);
        if3.tt_data = 8'hFF; if3.tt_wr = 1; if3.start = 1;
        @(negedge clk);
        if3.tt_wr = 0; if3.start = 0;
        for (int c = 0; c < 20 && !if3.done; c++) @(negedge clk);
        chk("col_done", 32'(if3.done), 1);
        chk("col_ones", 32'(if3.ones_count), 3);
        @(negedge clk);
        if3.inp = 3'd4;
        @(negedge clk);
        chk("col_out4", 32'(if3.out), 0);
        if3.inp = 3'd3;
        @(negedge clk);
        chk("col_out3", 32'(if3.out), 1);

        // reset at row 4
        if3.start = 1;
        @(negedge clk);
        if3.start = 0;
        repeat (4) @(negedge clk);
        chk("mid_idx", 32'(if3.s_idx), 4);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_zero3("mid_rst");
        @(negedge clk);
        chk("mid_tbl", 32'(if3.out), 0);
        chk("mid_nodone", 32'(if3.done), 0);

        // N=8 all-ones sweep, table written in the same cycle as start
        if8.tt_data = '1; if8.tt_wr = 1; if8.start = 1; if8.s_ready = 1;
        @(negedge clk);
        if8.tt_wr = 0; if8.start = 0;
        row = 0;
        for (int c = 0; c < 400 && !if8.done; c++) begin
            if (if8.s_valid) begin
                chk("w_idx", 32'(if8.s_idx), 32'(row));
                chk("w_bit", 32'(if8.s_bit), 1);
                row++;
            end
            @(negedge clk);
        end
        chk("w_rows", 32'(row), 256);
        chk("w_done", 32'(if8.done), 1);
        chk("w_ones", 32'(if8.ones_count), 256);
        @(negedge clk);
        chk("w_busy_fall", 32'(if8.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
